// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative RV32M multiply/divide unit for the EX stage. Operands arrive
//   after forwarding; the registered result feeds the EX result-select mux.
//   Multiplies use shift-add, divides use restoring division; both run on
//   operand magnitudes and fix up the sign at the end.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start
//   CALC  | one shift-add / restoring step per clock, N steps
//   FIX   | sign correction and output select, result register written
//   DONE  | done pulse; a new start may be accepted here
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   1-cycle request, sampled only in IDLE or DONE
//   kill    in   pipeline flush, aborts the operation in flight
//   funct3  in   M-extension operation select
//   rs1     in   operand A (dividend / multiplicand)
//   rs2     in   operand B (divisor / multiplier)
//   busy    out  high in CALC and FIX
//   done    out  1-cycle pulse, result valid
//   result  out  registered result, held until the next write
module mul_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         kill,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
    localparam logic [N-1:0]  MIN_NEG   = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2:0]     f3_q;
    logic           neg_q;
    logic [N-1:0]   mag_a, mag_b;
    logic [N-1:0]   hi, lo;

    // operand decode at accept
    logic           is_div, sgn_a, sgn_b, a_neg, b_neg, neg_res;
    logic [N-1:0]   a_abs, b_abs;
    logic           accept, div_zero, div_ovf, fast;
    logic [N-1:0]   fast_val;

    always_comb begin
        is_div  = funct3[2];
        // signed rs1: MULH, MULHSU, DIV, REM; signed rs2: MULH, DIV, REM
        sgn_a   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg   = sgn_a & rs1[N-1];
        b_neg   = sgn_b & rs2[N-1];
        a_abs   = a_neg ? -rs1 : rs1;
        b_abs   = b_neg ? -rs2 : rs2;
        // remainder takes the dividend's sign
        neg_res = (funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);

        accept   = ((state == S_IDLE) || (state == S_DONE)) && start && !kill;
        div_zero = is_div && (rs2 == '0);
        div_ovf  = is_div && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
        fast     = div_zero || div_ovf;
        fast_val = '0;
        if (div_zero)
            fast_val = funct3[1] ? rs1 : '1;
        else if (div_ovf)
            fast_val = funct3[1] ? '0 : rs1;
    end

    // one iteration step
    logic [N:0]     sum, sh, diff;
    logic           ge;
    logic [N-1:0]   hi_nxt, lo_nxt;

    always_comb begin
        sum  = {1'b0, hi} + {1'b0, mag_a & {N{lo[0]}}};
        sh   = {hi, lo[N-1]};
        diff = sh - {1'b0, mag_b};
        // hi < mag_b always holds, so no borrow means diff fits in N bits
        ge   = !diff[N];
        if (f3_q[2]) begin
            hi_nxt = ge ? diff[N-1:0] : sh[N-1:0];
            lo_nxt = {lo[N-2:0], ge};
        end else begin
            hi_nxt = sum[N:1];
            lo_nxt = {sum[0], lo[N-1:1]};
        end
    end

    // sign fix-up and output select
    logic [2*N-1:0] prod, prod_s;
    logic [N-1:0]   quo_s, rem_s, fix_val;

    always_comb begin
        prod   = {hi, lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -lo : lo;
        rem_s  = neg_q ? -hi : hi;
        case (f3_q)
            3'b000:                 fix_val = prod_s[N-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_s[2*N-1:N];
            3'b100, 3'b101:         fix_val = quo_s;
            default:                fix_val = rem_s;
        endcase
    end

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = fast ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (kill)
                    state_nxt = S_IDLE;
                else if (cnt == LAST_STEP)
                    state_nxt = S_FIX;
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = kill ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (accept)
                    state_nxt = fast ? S_DONE : S_CALC;
                else
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            f3_q   <= '0;
            neg_q  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
        end else if (accept) begin
            cnt   <= '0;
            f3_q  <= funct3;
            neg_q <= neg_res;
            mag_a <= a_abs;
            mag_b <= b_abs;
            hi    <= '0;
            // divide shifts the dividend out of lo; multiply shifts the multiplier
            lo    <= is_div ? a_abs : b_abs;
            if (fast)
                result <= fast_val;
        end else if (state == S_CALC) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_nxt;
            lo  <= lo_nxt;
        end else if ((state == S_FIX) && !kill) begin
            result <= fix_val;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(.N(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
    endtask

    // lat counts clock edges from the accepting edge (=1) to the first cycle with done
    task automatic wait_done(output logic [31:0] res, output int lat, output bit busy_seen);
        @(posedge clk); #1;
        start     = 1'b0;
        lat       = 1;
        busy_seen = busy;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            busy_seen |= busy;
        end
        res = result;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit busy_seen);
        @(negedge clk);
        issue(f, a, b);
        wait_done(res, lat, busy_seen);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] res;
        int          lat;
        bit          bs;
        bit          done_seen;

        vecs[0]  = '{"mul",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{"mulh",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34};
        vecs[2]  = '{"mulhsu",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34};
        vecs[3]  = '{"mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[4]  = '{"div",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[5]  = '{"rem",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[6]  = '{"divu",     3'b101, 32'd100,      32'd7,        32'd14,       34};
        vecs[7]  = '{"remu",     3'b111, 32'd100,      32'd7,        32'd2,        34};
        vecs[8]  = '{"div_z",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{"remu_z",   3'b111, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{"div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{"rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

        rst_n = 1'b0; start = 1'b0; kill = 1'b0;
        funct3 = '0; rs1 = '0; rs2 = '0;
        #12;
        check_val("rst_busy",   32'(busy), 32'd0);
        check_val("rst_done",   32'(done), 32'd0);
        check_val("rst_result", result,    32'd0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bs);
            check_val({vecs[i].name, "_res"}, res, vecs[i].exp);
            check_val({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].lat == 1)
                check_val({vecs[i].name, "_busy"}, 32'(bs), 32'd0);
        end

        // start during CALC must be ignored
        @(negedge clk); issue(3'b101, 32'd100, 32'd7);
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); issue(3'b000, 32'd3, 32'd3);
        @(posedge clk); #1; start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        check_val("ign_start_res", result, 32'd14);
        check_val("ign_start_done", 32'(done), 32'd1);

        // back-to-back: second op started in the DONE cycle
        run_op(3'b111, 32'd100, 32'd7, res, lat, bs);
        check_val("b2b_first", res, 32'd2);
        issue(3'b101, 32'd100, 32'd7);
        wait_done(res, lat, bs);
        check_val("b2b_second", res, 32'd14);
        check_val("b2b_lat", 32'(lat), 32'd34);

        // kill in CALC cycle 20: result stays 14, no done
        @(negedge clk); issue(3'b100, 32'hFFFFFFF9, 32'd2);
        @(posedge clk); #1; start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        check_val("kill_busy", 32'(busy), 32'd0);
        done_seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; done_seen |= done; end
        check_val("kill_no_done", 32'(done_seen), 32'd0);
        check_val("kill_result", result, 32'd14);

        // kill together with start: nothing accepted
        @(negedge clk); issue(3'b101, 32'd9, 32'd3); kill = 1'b1;
        @(posedge clk); #1; start = 1'b0; kill = 1'b0;
        check_val("killstart_busy", 32'(busy), 32'd0);
        check_val("killstart_done", 32'(done), 32'd0);

        // async reset mid-DIV
        @(negedge clk); issue(3'b100, 32'd1000, 32'd3);
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy",   32'(busy), 32'd0);
        check_val("mid_rst_done",   32'(done), 32'd0);
        check_val("mid_rst_result", result,    32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(3'b100, 32'd1000, 32'd3, res, lat, bs);
        check_val("post_rst_res", res, 32'd333);
        check_val("post_rst_lat", 32'(lat), 32'd34);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
